// File: rtl/pong_pkg.sv
// Shared constants for the pong score overlay: default digit geometry,
// the 7-segment ROM, FSM state encoding and winner codes.
package pong_pkg;

  localparam int SEG_LEN_DEF = 20;
  localparam int SEG_W_DEF   = 4;
  localparam int DIGIT_W     = SEG_LEN_DEF + 2 * SEG_W_DEF;
  localparam int DIGIT_H     = 2 * SEG_LEN_DEF + 3 * SEG_W_DEF;

  // Segment patterns, bit order gfedcba (bit 0 = a); index = digit value.
  localparam logic [9:0][6:0] SEG_ROM = {
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

  typedef enum logic [1:0] {
    ST_PLAY = 2'b00,
    ST_WIN1 = 2'b01,
    ST_WIN2 = 2'b10
  } state_t;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  // Displayed digit: the full 10-bit score saturated at 9.
  function automatic logic [3:0] digit_val(input logic [9:0] score);
    return (score > 10'd9) ? 4'd9 : score[3:0];
  endfunction

endpackage

// File: rtl/seven_seg_hit.sv
// Combinational segment hit test for one digit box: given the pixel offset
// inside the box, reports which of the seven segment rectangles it falls in.
module seven_seg_hit #(
  parameter int SEG_LEN = 20,
  parameter int SEG_W   = 4
) (
  input  logic [9:0] rx,
  input  logic [9:0] ry,
  input  logic       in_box,
  output logic [6:0] hit
);

  localparam logic [9:0] XA = 10'(0);
  localparam logic [9:0] XB = 10'(SEG_W);
  localparam logic [9:0] XC = 10'(SEG_W + SEG_LEN);
  localparam logic [9:0] XD = 10'(2 * SEG_W + SEG_LEN);
  localparam logic [9:0] YA = 10'(0);
  localparam logic [9:0] YB = 10'(SEG_W);
  localparam logic [9:0] YC = 10'(SEG_W + SEG_LEN);
  localparam logic [9:0] YD = 10'(2 * SEG_W + SEG_LEN);
  localparam logic [9:0] YE = 10'(2 * SEG_W + 2 * SEG_LEN);
  localparam logic [9:0] YF = 10'(3 * SEG_W + 2 * SEG_LEN);

  function automatic logic in_rng(input logic [9:0] v, input logic [9:0] lo,
                                  input logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

  // Half-open rectangle tests, gated by the box flag so offsets outside
  // the box can never light a segment.
  always_comb begin
    hit = '0;
    if (in_box) begin
      hit[0] = in_rng(rx, XB, XC) && in_rng(ry, YA, YB);  // a
      hit[1] = in_rng(rx, XC, XD) && in_rng(ry, YB, YC);  // b
      hit[2] = in_rng(rx, XC, XD) && in_rng(ry, YD, YE);  // c
      hit[3] = in_rng(rx, XB, XC) && in_rng(ry, YE, YF);  // d
      hit[4] = in_rng(rx, XA, XB) && in_rng(ry, YD, YE);  // e
      hit[5] = in_rng(rx, XA, XB) && in_rng(ry, YB, YC);  // f
      hit[6] = in_rng(rx, XB, XC) && in_rng(ry, YC, YD);  // g
    end
  end

endmodule

// File: rtl/score_overlay.sv
// Score overlay for the pong display: draws both scores as 7-segment digits,
// tracks the win state once per frame and flashes the winner's digit green.
//
// state   | meaning
// --------+------------------------------------------------
// PLAY    | game in progress, both digits drawn white
// WIN1    | player 1 reached the win score, digit 1 blinks
// WIN2    | player 2 reached the win score, digit 2 blinks
module score_overlay
  import pong_pkg::*;
#(
  parameter int DIGIT1_X     = 240,
  parameter int DIGIT2_X     = 368,
  parameter int DIGIT_Y      = 16,
  parameter int SEG_LEN      = 20,
  parameter int SEG_W        = 4,
  parameter int V_ACTIVE     = 480,
  parameter int WIN_SCORE    = 5,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       enable,
  input  logic [9:0] score1,
  input  logic [9:0] score2,
  output logic       red,
  output logic       green,
  output logic       blue,
  output logic       layer,
  output logic [1:0] winner
);

  localparam logic [9:0] X1_C    = 10'(DIGIT1_X);
  localparam logic [9:0] X2_C    = 10'(DIGIT2_X);
  localparam logic [9:0] Y_C     = 10'(DIGIT_Y);
  localparam logic [9:0] BOX_W_C = 10'(SEG_LEN + 2 * SEG_W);
  localparam logic [9:0] BOX_H_C = 10'(2 * SEG_LEN + 3 * SEG_W);
  localparam logic [9:0] VACT_C  = 10'(V_ACTIVE);
  localparam logic [9:0] WIN_C   = 10'(WIN_SCORE);
  localparam int         CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  // ---------------- stage 1: box and segment hit tests ----------------
  logic [9:0] dx1, dx2, dy;
  logic       in_y, in1, in2;
  logic [6:0] hit1, hit2;

  // Compare before using the difference so pixels left of / above a box
  // never wrap around into it.
  always_comb begin
    dx1  = hcount - X1_C;
    dx2  = hcount - X2_C;
    dy   = vcount - Y_C;
    in_y = (vcount >= Y_C) && (dy < BOX_H_C);
    in1  = (hcount >= X1_C) && (dx1 < BOX_W_C) && in_y;
    in2  = (hcount >= X2_C) && (dx2 < BOX_W_C) && in_y;
  end

  seven_seg_hit #(.SEG_LEN(SEG_LEN), .SEG_W(SEG_W)) u_hit1 (
    .rx    (dx1),
    .ry    (dy),
    .in_box(in1),
    .hit   (hit1)
  );

  seven_seg_hit #(.SEG_LEN(SEG_LEN), .SEG_W(SEG_W)) u_hit2 (
    .rx    (dx2),
    .ry    (dy),
    .in_box(in2),
    .hit   (hit2)
  );

  logic       in1_q, in2_q, en_q;
  logic [6:0] hit1_q, hit2_q;

  // Stage 1 register: advances every clock, enable travels with the pixel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in1_q  <= 1'b0;
      in2_q  <= 1'b0;
      hit1_q <= '0;
      hit2_q <= '0;
      en_q   <= 1'b0;
    end else begin
      in1_q  <= in1;
      in2_q  <= in2;
      hit1_q <= hit1;
      hit2_q <= hit2;
      en_q   <= enable;
    end
  end

  // ---------------- frame tick and win FSM ----------------
  state_t          state_q, state_d;
  logic [1:0]      winner_d;
  logic            tick_cond, tick_cond_q, frame_tick;
  logic [CNT_W-1:0] blink_cnt;
  logic            blink_phase;
  logic            s1_win, s2_win;

  // Tick on the rising edge of the start-of-blanking condition only.
  always_comb begin
    tick_cond  = (hcount == 10'd0) && (vcount == VACT_C) && enable;
    frame_tick = tick_cond && !tick_cond_q;
    s1_win     = (score1 >= WIN_C);
    s2_win     = (score2 >= WIN_C);
  end

  // Registered copy of the tick condition for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) tick_cond_q <= 1'b0;
    else          tick_cond_q <= tick_cond;
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_PLAY;
    else          state_q <= state_d;
  end

  // FSM next state: moves only on a frame tick, never WIN1 <-> WIN2.
  always_comb begin
    state_d = state_q;
    if (frame_tick) begin
      case (state_q)
        ST_PLAY: begin
          if (s1_win)      state_d = ST_WIN1;
          else if (s2_win) state_d = ST_WIN2;
        end
        ST_WIN1, ST_WIN2: begin
          if (!s1_win && !s2_win) state_d = ST_PLAY;
        end
        default: state_d = ST_PLAY;
      endcase
    end
  end

  // FSM output decode to winner code.
  always_comb begin
    winner_d = WINNER_NONE;
    case (state_q)
      ST_WIN1: winner_d = WINNER_P1;
      ST_WIN2: winner_d = WINNER_P2;
      default: winner_d = WINNER_NONE;
    endcase
  end

  // winner lags the state by one clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) winner <= WINNER_NONE;
    else          winner <= winner_d;
  end

  // Blink timer: parked at 0 / phase 1 in PLAY, which also primes it for
  // entry into a WIN state; counts frame ticks while a player has won.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (state_q == ST_PLAY) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt == CNT_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // ---------------- stage 2: pattern, colour, blink ----------------
  logic       lit1, lit2, flash1, flash2;
  logic [2:0] rgb_d;

  // Digit 1 wins any overlap; a flashing digit is green or dark by phase.
  always_comb begin
    lit1   = |(hit1_q & SEG_ROM[digit_val(score1)]);
    lit2   = |(hit2_q & SEG_ROM[digit_val(score2)]);
    flash1 = (state_q == ST_WIN1);
    flash2 = (state_q == ST_WIN2);
    rgb_d  = 3'b000;
    if (en_q) begin
      if (in1_q) begin
        if (lit1) rgb_d = flash1 ? (blink_phase ? 3'b010 : 3'b000) : 3'b111;
      end else if (in2_q) begin
        if (lit2) rgb_d = flash2 ? (blink_phase ? 3'b010 : 3'b000) : 3'b111;
      end
    end
  end

  // Output register; layer claims the pixel whenever anything is drawn.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      red   <= 1'b0;
      green <= 1'b0;
      blue  <= 1'b0;
      layer <= 1'b0;
    end else begin
      red   <= rgb_d[2];
      green <= rgb_d[1];
      blue  <= rgb_d[0];
      layer <= |rgb_d;
    end
  end

endmodule

// File: tb/tb_score_overlay.sv
// Directed bench for score_overlay: pixel vector table plus hand-written
// win / blink / reset sequences.
module tb_score_overlay;

  logic       clock;
  logic       reset_n;
  logic [9:0] hcount, vcount, score1, score2;
  logic       enable;
  logic       red, green, blue, layer;
  logic [1:0] winner;

  int total = 0;
  int bad   = 0;

  score_overlay dut (
    .clock  (clock),
    .reset_n(reset_n),
    .hcount (hcount),
    .vcount (vcount),
    .enable (enable),
    .score1 (score1),
    .score2 (score2),
    .red    (red),
    .green  (green),
    .blue   (blue),
    .layer  (layer),
    .winner (winner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic       en;
    logic [9:0] s1;
    logic [9:0] s2;
    logic [3:0] exp;  // {r,g,b,layer}
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] pix();
    return {red, green, blue, layer};
  endfunction

  // Present a pixel at a negedge and wait for it to reach the outputs.
  task automatic show(input logic [9:0] h, input logic [9:0] v, input logic e);
    hcount = h;
    vcount = v;
    enable = e;
    repeat (2) @(negedge clock);
  endtask

  // n frame ticks, each with hcount held at 0 on the tick line for hold clocks.
  task automatic ticks(input int n, input int hold);
    for (int k = 0; k < n; k++) begin
      hcount = 10'd0;
      vcount = 10'd480;
      enable = 1'b1;
      repeat (hold) @(negedge clock);
      hcount = 10'd100;
      vcount = 10'd100;
      @(negedge clock);
    end
  endtask

  initial begin
    vecs[0]  = '{10'd249, 10'd17, 1'b1, 10'd8,    10'd0,  4'b1111};
    vecs[1]  = '{10'd249, 10'd17, 1'b1, 10'd1,    10'd0,  4'b0000};
    vecs[2]  = '{10'd265, 10'd26, 1'b1, 10'd1,    10'd0,  4'b1111};
    vecs[3]  = '{10'd239, 10'd26, 1'b1, 10'd1,    10'd0,  4'b0000};
    vecs[4]  = '{10'd378, 10'd41, 1'b1, 10'd0,    10'd12, 4'b1111};
    vecs[5]  = '{10'd369, 10'd46, 1'b1, 10'd0,    10'd12, 4'b0000};
    vecs[6]  = '{10'd395, 10'd26, 1'b1, 10'd0,    10'd12, 4'b1111};
    vecs[7]  = '{10'd396, 10'd26, 1'b1, 10'd0,    10'd12, 4'b0000};
    vecs[8]  = '{10'd250, 10'd66, 1'b1, 10'd0,    10'd0,  4'b1111};
    vecs[9]  = '{10'd250, 10'd41, 1'b1, 10'd0,    10'd0,  4'b0000};
    vecs[10] = '{10'd249, 10'd17, 1'b1, 10'd1023, 10'd0,  4'b1111};
    vecs[11] = '{10'd241, 10'd46, 1'b1, 10'd10,   10'd0,  4'b0000};
    vecs[12] = '{10'd249, 10'd15, 1'b1, 10'd8,    10'd0,  4'b0000};
    vecs[13] = '{10'd249, 10'd17, 1'b0, 10'd8,    10'd0,  4'b0000};
    vecs[14] = '{10'd267, 10'd67, 1'b1, 10'd8,    10'd0,  4'b0000};
    vecs[15] = '{10'd244, 10'd19, 1'b1, 10'd8,    10'd0,  4'b1111};
    vecs[16] = '{10'd243, 10'd19, 1'b1, 10'd8,    10'd0,  4'b0000};

    reset_n = 1'b0;
    hcount  = 10'd100;
    vcount  = 10'd100;
    enable  = 1'b1;
    score1  = 10'd0;
    score2  = 10'd0;
    repeat (2) @(negedge clock);
    chk("reset_pix", pix(), 4'b0000);
    chk("reset_winner", {2'b00, winner}, 4'b0000);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Two-cycle latency: lit pixel not visible after one clock.
    score1 = 10'd8;
    hcount = 10'd249;
    vcount = 10'd17;
    @(negedge clock);
    chk("latency_1clk", pix(), 4'b0000);
    @(negedge clock);
    chk("latency_2clk", pix(), 4'b1111);

    for (int i = 0; i < 17; i++) begin
      score1 = vecs[i].s1;
      score2 = vecs[i].s2;
      show(vecs[i].h, vecs[i].v, vecs[i].en);
      chk($sformatf("vec%0d", i), pix(), vecs[i].exp);
    end

    // Player 1 wins: winner one clock after the state moves.
    score1 = 10'd5;
    score2 = 10'd0;
    hcount = 10'd0;
    vcount = 10'd480;
    enable = 1'b1;
    @(negedge clock);
    hcount = 10'd249;
    vcount = 10'd17;
    chk("win1_winner_lag", {2'b00, winner}, 4'b0000);
    @(negedge clock);
    chk("win1_winner", {2'b00, winner}, 4'b0001);
    @(negedge clock);
    chk("win1_green", pix(), 4'b0101);

    ticks(29, 1);
    show(10'd249, 10'd17, 1'b1);
    chk("blink_29_green", pix(), 4'b0101);
    ticks(1, 1);
    show(10'd249, 10'd17, 1'b1);
    chk("blink_30_off", pix(), 4'b0000);
    ticks(29, 1);
    show(10'd249, 10'd17, 1'b1);
    chk("blink_59_off", pix(), 4'b0000);
    ticks(1, 1);
    show(10'd249, 10'd17, 1'b1);
    chk("blink_60_green", pix(), 4'b0101);

    score1 = 10'd0;
    ticks(1, 1);
    chk("win1_to_play", {2'b00, winner}, 4'b0000);

    // No direct WIN1 -> WIN2.
    score1 = 10'd5;
    ticks(1, 1);
    chk("win1_again", {2'b00, winner}, 4'b0001);
    score1 = 10'd0;
    score2 = 10'd5;
    ticks(1, 1);
    chk("no_win1_to_win2", {2'b00, winner}, 4'b0001);
    score2 = 10'd0;
    ticks(1, 1);
    chk("back_to_play", {2'b00, winner}, 4'b0000);

    // Both qualify together, hcount held 4 clocks: one tick only.
    score1 = 10'd5;
    score2 = 10'd7;
    ticks(1, 4);
    chk("both_win1_prio", {2'b00, winner}, 4'b0001);
    ticks(29, 1);
    show(10'd249, 10'd17, 1'b1);
    chk("held_single_tick", pix(), 4'b0101);
    show(10'd393, 10'd26, 1'b1);
    chk("loser_white", pix(), 4'b1111);

    score1 = 10'd0;
    score2 = 10'd0;
    ticks(1, 1);
    score2 = 10'd5;
    ticks(1, 1);
    chk("win2_winner", {2'b00, winner}, 4'b0010);
    show(10'd378, 10'd41, 1'b1);
    chk("win2_green", pix(), 4'b0101);
    show(10'd249, 10'd17, 1'b1);
    chk("win2_digit1_white", pix(), 4'b1111);
    show(10'd249, 10'd17, 1'b0);
    chk("enable_low", pix(), 4'b0000);
    show(10'd249, 10'd17, 1'b1);
    chk("pre_reset_lit", pix(), 4'b1111);

    // Asynchronous reset mid-frame while in WIN2.
    reset_n = 1'b0;
    #1;
    chk("async_rst_pix", pix(), 4'b0000);
    chk("async_rst_winner", {2'b00, winner}, 4'b0000);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_1clk", pix(), 4'b0000);
    @(negedge clock);
    chk("post_rst_2clk", pix(), 4'b1111);
    chk("post_rst_winner", {2'b00, winner}, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_overlay.md
Name: score_overlay

Overview:
- Renders both players' scores as 7-segment digits near the top of the 640x480 frame for the pong display.
- Sits downstream of the ball/game block: consumes its score1/score2 and shares the hcount/vcount/enable pixel bus with it.
- Adds a win-state FSM that flashes the winner's digit.
- Produces 1-bit RGB plus a layer flag for the display mixer.

Parameters:
- DIGIT1_X, 240, left edge of player-1 digit (pixels)
- DIGIT2_X, 368, left edge of player-2 digit
- DIGIT_Y, 16, top edge of both digits
- SEG_LEN, 20, segment length (pixels)
- SEG_W, 4, segment thickness (pixels)
- V_ACTIVE, 480, first non-visible line, used for frame tick
- WIN_SCORE, 5, score at or above which a player has won
- BLINK_FRAMES, 30, frames per blink half-period

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- hcount  in  10  current pixel column
- vcount  in  10  current pixel line
- enable  in  1  pixel-valid strobe for the current hcount/vcount
- score1  in  10  player-1 score
- score2  in  10  player-2 score
- red  out  1  pixel red
- green  out  1  pixel green
- blue  out  1  pixel blue
- layer  out  1  1 = this block owns the pixel (overlay priority)
- winner  out  2  00 = play, 01 = player 1 won, 10 = player 2 won

Behaviour:
- Interface: one clock, `clock`. Reset is asynchronous and active-low, on port `reset_n`.
- Reset values: red, green, blue, layer = 0; winner = 00; FSM = PLAY; blink_cnt = 0; blink_phase = 1; pipeline registers = 0.
- Digit value: min(score, 9), computed on the full 10-bit value. 0 displays "0"; 10 or more displays "9".
- Digit box: 28 x 52 pixels (SEG_LEN + 2*SEG_W by 2*SEG_LEN + 3*SEG_W). In-box test: hcount >= Xn and hcount - Xn < 28, with the same rule for vcount against DIGIT_Y.
  - Compare before subtracting, so coordinates left of or above the box never wrap into a hit.
- Segment regions, relative rx,ry, half-open ranges (default geometry):
  - a: x[4,24) y[0,4)
  - b: x[24,28) y[4,24)
  - c: x[24,28) y[28,48)
  - d: x[4,24) y[48,52)
  - e: x[0,4) y[28,48)
  - f: x[0,4) y[4,24)
  - g: x[4,24) y[24,28)
- Segment ROM (gfedcba): the standard decimal pattern. Digit 7 lights a, b, c; digit 9 lights a, b, c, d, f, g.
- Pipeline, latency 2 cycles from hcount/vcount/enable to rgb/layer:
  - Stage 1 registers the in-box flags, both 7-bit segment hit masks and enable.
  - Stage 2 ANDs the masks with the ROM patterns and applies colour and blink.
  - Both stages advance every clock regardless of enable.
- Pixel output:
  - If stage-2 enable = 0, rgb = 000 and layer = 0.
  - A lit pixel of a non-flashing digit is white (111).
  - The winner's digit is green (010) when blink_phase = 1 and off when blink_phase = 0.
  - layer = 1 exactly when rgb != 000.
  - The two digit boxes never overlap at the default geometry; if parameters make them overlap, player 1 takes priority.
- Frame tick: a one-cycle pulse on the rising edge of (hcount == 0 and vcount == V_ACTIVE and enable), edge-detected with a registered copy. It fires once per frame even when hcount is held for several clocks.
- FSM, all transitions evaluated only on a frame tick:
  - PLAY -> WIN1 if score1 >= WIN_SCORE.
  - PLAY -> WIN2 if score2 >= WIN_SCORE (and score1 < WIN_SCORE).
  - If both scores qualify on the same tick, WIN1 takes priority.
  - WIN1 or WIN2 -> PLAY when score1 < WIN_SCORE and score2 < WIN_SCORE.
  - WIN1 <-> WIN2 is never taken directly.
- winner is registered from the FSM state, so it changes one cycle after the tick.
- Blink:
  - On entering WIN1/WIN2: blink_cnt = 0 and blink_phase = 1.
  - Each tick in a WIN state increments blink_cnt. At BLINK_FRAMES-1 the counter wraps to 0 and blink_phase toggles.
  - In PLAY: blink_cnt is held at 0 and blink_phase at 1.
- Reset mid-frame: outputs go to 0 immediately (asynchronous). The first valid pixel appears 2 cycles after reset_n rises. No frame tick is generated from stale history.

Decomposition:
- Package pong_pkg holds:
  - geometry constants (digit box width/height)
  - the 10-entry x 7-bit segment ROM constant
  - FSM state encoding (PLAY, WIN1, WIN2)
  - winner encodings
- Sub-module seven_seg_hit: combinational; inputs rx, ry and in-box flag; output a 7-bit segment hit mask. Instantiated twice, once per digit.

Test Plan:
- score1 = 8, enable = 1, hcount = 249, vcount = 17 (segment a) -> rgb = 111 and layer = 1 exactly 2 cycles later; with score1 = 1 at the same pixel -> rgb = 000, layer = 0.
- score1 = 1, hcount = 265, vcount = 26 (segment b) -> 111; hcount = 239 (left of box) -> 000, no wrap hit.
- score2 = 12 -> shown as 9:
  - hcount = 378, vcount = 41 (segment g) -> 111
  - hcount = 369, vcount = 46 (segment e) -> 000
- score1 = 5, one frame tick -> winner = 01 on the next cycle and digit-1 segment pixels green.
  - After 30 ticks the digit-1 segments are off; after 60 ticks they are green again.
  - Set score1 = 0 -> winner = 00 after the next tick.
- score1 = 5 and score2 = 7 reached on the same tick -> winner = 01. hcount held at 0 for 4 clocks on line 480 -> exactly one tick.
- enable = 0 on a lit pixel -> rgb = 000. Pulse reset_n low while in WIN2 -> outputs 0 immediately, winner = 00, first valid pixel 2 cycles after release.
